lc3_mem_io_ctrl: RTL and testbench

//  Address-control and memory-mapped I/O stage behind the MAR/MDR memory unit.

---
 rtl/lc3_mem_io_ctrl.sv | 151 +++++++++++++++
 tb/tb_lc3_mem_io_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_io_ctrl.sv
// LC-3 memory address control and memory-mapped I/O (KBSR/KBDR/DSR/DDR) stage.
// Optional keyboard interrupt enabled by defining LC3_KB_INT_EN.
module lc3_mem_io_ctrl #(
    parameter int          MEM_WAIT  = 2,
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        MIOEN,
    input  logic        RW,
    output logic        R,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        INT
);

    localparam int CW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          rw_q;
    logic          kbsr15;
    logic          kbsr14;
    logic [7:0]    kbdr;
    logic          dsr15;
    logic [15:0]   io_rdata;
    logic          is_io;

    assign kb_ready = ~kbsr15;
    assign is_io    = (MAR[15:9] == 7'h7F);

    // Read value of the addressed I/O register, sampled as the access is accepted.
    always_comb begin
        io_rdata = 16'h0000;
        if (MAR == KBSR_ADDR)
            io_rdata = {kbsr15, kbsr14, 14'b0};
        else if (MAR == KBDR_ADDR)
            io_rdata = {8'b0, kbdr};
        else if (MAR == DSR_ADDR)
            io_rdata = {dsr15, 15'b0};
    end

    // Access FSM plus keyboard/display register state; I/O side effects land in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            rw_q       <= 1'b0;
            R          <= 1'b0;
            rdata      <= 16'h0000;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            kbsr15     <= 1'b0;
            kbdr       <= 8'h00;
            dsr15      <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            R <= 1'b0;
            if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
                dsr15      <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (MIOEN) begin
                        mem_addr  <= MAR;
                        mem_wdata <= MDR;
                        rw_q      <= RW;
                        if (is_io) begin
                            state <= DONE;
                            R     <= 1'b1;
                            if (!RW)
                                rdata <= io_rdata;
                        end else begin
                            state    <= MEM;
                            mem_en   <= 1'b1;
                            mem_we   <= RW;
                            wait_cnt <= CW'(1);
                        end
                    end
                end
                MEM: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (!rw_q)
                            rdata <= mem_rdata;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        R      <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!rw_q && mem_addr == KBDR_ADDR)
                        kbsr15 <= 1'b0;
                    if (rw_q && mem_addr == DDR_ADDR) begin
                        disp_data  <= mem_wdata[7:0];
                        dsr15      <= 1'b0;
                        disp_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (kb_valid && kb_ready) begin
                kbdr   <= kb_data;
                kbsr15 <= 1'b1;
            end
        end
    end

`ifdef LC3_KB_INT_EN
    // Interrupt enable bit and registered interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbsr14 <= 1'b0;
            INT    <= 1'b0;
        end else begin
            if (state == DONE && rw_q && mem_addr == KBSR_ADDR)
                kbsr14 <= mem_wdata[14];
            INT <= kbsr15 & kbsr14;
        end
    end
`else
    assign kbsr14 = 1'b0;
    assign INT    = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_io_ctrl.sv
// Directed self-checking bench for lc3_mem_io_ctrl (MEM_WAIT=2).
// Interrupt expectations follow LC3_KB_INT_EN when defined.
module tb_lc3_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        MIOEN;
    logic        RW;
    logic        R;
    logic [15:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        INT;

    int checks   = 0;
    int failures = 0;

`ifdef LC3_KB_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    lc3_mem_io_ctrl #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .MAR(MAR), .MDR(MDR), .MIOEN(MIOEN), .RW(RW),
        .R(R), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .INT(INT)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mioen, input logic rw,
                                 input logic [15:0] mar, input logic [15:0] mdr);
        MIOEN = mioen;
        RW    = rw;
        MAR   = mar;
        MDR   = mdr;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        mem_rdata  = 16'h0000;
        kb_valid   = 1'b0;
        kb_data    = 8'h00;
        disp_ready = 1'b0;
        tick();
        tick();
        $display("[TB] reset values");
        checkOutput("rst_R", {15'b0, R}, 16'h0000);
        checkOutput("rst_rdata", rdata, 16'h0000);
        checkOutput("rst_mem_en", {15'b0, mem_en}, 16'h0000);
        checkOutput("rst_mem_we", {15'b0, mem_we}, 16'h0000);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0000);
        checkOutput("rst_kb_ready", {15'b0, kb_ready}, 16'h0001);
        checkOutput("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        checkOutput("rst_disp_data", {8'b0, disp_data}, 16'h0000);
        checkOutput("rst_INT", {15'b0, INT}, 16'h0000);
        reset = 1'b0;
        tick();

        $display("[TB] memory read with held MIOEN");
        mem_rdata = 16'hBEEF;
        applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0000);
        tick();
        checkOutput("rd_t1_mem_en", {15'b0, mem_en}, 16'h0001);
        checkOutput("rd_t1_mem_we", {15'b0, mem_we}, 16'h0000);
        checkOutput("rd_t1_R", {15'b0, R}, 16'h0000);
        checkOutput("rd_t1_addr", mem_addr, 16'h3000);
        MAR = 16'h1234;
        tick();
        checkOutput("rd_t2_mem_en", {15'b0, mem_en}, 16'h0001);
        checkOutput("rd_t2_R", {15'b0, R}, 16'h0000);
        tick();
        checkOutput("rd_t3_R", {15'b0, R}, 16'h0001);
        checkOutput("rd_t3_rdata", rdata, 16'hBEEF);
        checkOutput("rd_t3_mem_en", {15'b0, mem_en}, 16'h0000);
        checkOutput("rd_addr_kept", mem_addr, 16'h3000);
        mem_rdata = 16'h0000;
        tick();
        checkOutput("rd_t4_R", {15'b0, R}, 16'h0000);
        checkOutput("rd_rdata_held", rdata, 16'hBEEF);
        MIOEN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("held_no_R", {15'b0, R}, 16'h0000);
            checkOutput("held_no_mem_en", {15'b0, mem_en}, 16'h0000);
        end

        $display("[TB] memory write");
        applyStimulus(1'b1, 1'b1, 16'h4000, 16'hABCD);
        tick();
        checkOutput("wr_mem_en", {15'b0, mem_en}, 16'h0001);
        checkOutput("wr_mem_we", {15'b0, mem_we}, 16'h0001);
        checkOutput("wr_wdata", mem_wdata, 16'hABCD);
        MDR = 16'h5555;
        tick();
        tick();
        checkOutput("wr_R", {15'b0, R}, 16'h0001);
        checkOutput("wr_mem_we_off", {15'b0, mem_we}, 16'h0000);
        checkOutput("wr_wdata_kept", mem_wdata, 16'hABCD);
        tick();
        MIOEN = 1'b0;
        tick();

        $display("[TB] keyboard input");
        kb_valid = 1'b1;
        kb_data  = 8'h41;
        tick();
        kb_valid = 1'b0;
        checkOutput("kb_full", {15'b0, kb_ready}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'hFE00, 16'h0000);
        tick();
        checkOutput("kbsr_R", {15'b0, R}, 16'h0001);
        checkOutput("kbsr_rdata", rdata, 16'h8000);
        checkOutput("kbsr_no_mem", {15'b0, mem_en}, 16'h0000);
        MIOEN = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 16'hFE02, 16'h0000);
        tick();
        checkOutput("kbdr_R", {15'b0, R}, 16'h0001);
        checkOutput("kbdr_rdata", rdata, 16'h0041);
        MIOEN = 1'b0;
        tick();
        checkOutput("kb_ready_after", {15'b0, kb_ready}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 16'hFE00, 16'h0000);
        tick();
        checkOutput("kbsr_cleared", rdata, 16'h0000);
        MIOEN = 1'b0;
        tick();

        $display("[TB] display output");
        applyStimulus(1'b1, 1'b1, 16'hFE06, 16'h0058);
        tick();
        checkOutput("ddr_R", {15'b0, R}, 16'h0001);
        MIOEN = 1'b0;
        tick();
        checkOutput("disp_valid_set", {15'b0, disp_valid}, 16'h0001);
        checkOutput("disp_data", {8'b0, disp_data}, 16'h0058);
        applyStimulus(1'b1, 1'b0, 16'hFE04, 16'h0000);
        tick();
        checkOutput("dsr_pending", rdata, 16'h0000);
        MIOEN = 1'b0;
        tick();
        checkOutput("disp_still_valid", {15'b0, disp_valid}, 16'h0001);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        checkOutput("disp_valid_clr", {15'b0, disp_valid}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'hFE04, 16'h0000);
        tick();
        checkOutput("dsr_ready", rdata, 16'h8000);
        MIOEN = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 16'hFE08, 16'h0000);
        tick();
        checkOutput("unmapped_rd", rdata, 16'h0000);
        MIOEN = 1'b0;
        tick();

        $display("[TB] keyboard interrupt");
        applyStimulus(1'b1, 1'b1, 16'hFE00, 16'h4000);
        tick();
        MIOEN = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 16'hFE00, 16'h0000);
        tick();
        checkOutput("kbsr_ie", rdata, INT_EN ? 16'h4000 : 16'h0000);
        MIOEN = 1'b0;
        tick();
        kb_valid = 1'b1;
        kb_data  = 8'h42;
        tick();
        kb_valid = 1'b0;
        checkOutput("int_not_yet", {15'b0, INT}, 16'h0000);
        tick();
        checkOutput("int_set", {15'b0, INT}, {15'b0, INT_EN});
        applyStimulus(1'b1, 1'b0, 16'hFE02, 16'h0000);
        tick();
        checkOutput("int_kbdr", rdata, 16'h0042);
        MIOEN = 1'b0;
        tick();
        tick();
        checkOutput("int_cleared", {15'b0, INT}, 16'h0000);

        $display("[TB] reset mid-access");
        applyStimulus(1'b1, 1'b1, 16'h5000, 16'h1111);
        tick();
        checkOutput("mid_mem_en", {15'b0, mem_en}, 16'h0001);
        reset = 1'b1;
        tick();
        checkOutput("abort_mem_en", {15'b0, mem_en}, 16'h0000);
        checkOutput("abort_mem_we", {15'b0, mem_we}, 16'h0000);
        checkOutput("abort_R", {15'b0, R}, 16'h0000);
        checkOutput("abort_addr", mem_addr, 16'h0000);
        checkOutput("abort_wdata", mem_wdata, 16'h0000);
        checkOutput("abort_rdata", rdata, 16'h0000);
        reset = 1'b0;
        MIOEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_R", {15'b0, R}, 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 16'hFE04, 16'h0000);
        tick();
        checkOutput("idle_after_rst", {15'b0, R}, 16'h0001);
        checkOutput("dsr_after_rst", rdata, 16'h8000);
        MIOEN = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
